// File: rtl/banked_mem_ctrl.sv
// ez8 data-memory controller: special registers, I/O window, indirect pointers,
// banked GP RAM and a vectored, edge-latched interrupt controller.
//
// state     | meaning
// S_IDLE    | no interrupt in service, a take may occur
// S_SERVICE | interrupt in service, irq_vector held until retint
module banked_mem_ctrl #(
   parameter int DATA_W    = 8,
   parameter int NUM_BANKS = 4,
   parameter int NUM_INDIR = 4,
   parameter int NUM_IRQ   = 8,
   parameter int GP_DEPTH  = 240
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pause,
   input  logic [7:0]         writeaddr,
   input  logic [DATA_W-1:0]  writedata,
   input  logic               write_en,
   input  logic [7:0]         readaddr,
   input  logic [1:0]         indir_sel,
   input  logic               indir_read_en,
   input  logic               indir_postinc,
   output logic [DATA_W-1:0]  readdata,
   output logic [7:0]         readaddr_out,
   input  logic               zin,
   input  logic               z_write,
   input  logic               cin,
   input  logic               c_write,
   output logic               cout,
   input  logic [NUM_IRQ-1:0] io_irq,
   output logic [4:0]         io_readaddr,
   input  logic [DATA_W-1:0]  io_readdata,
   output logic [4:0]         io_writeaddr,
   output logic [DATA_W-1:0]  io_writedata,
   output logic               io_write_en,
   output logic               interrupt,
   output logic [2:0]         irq_vector,
   input  logic               retint,
   input  logic               save_accum,
   input  logic               accum_write,
   output logic [DATA_W-1:0]  accum_out
);

   localparam int BANK_W = (NUM_BANKS > 2) ? 2 : 1;
   localparam int GP_AW  = $clog2(GP_DEPTH);

   typedef enum logic {S_IDLE, S_SERVICE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_gie, r_c, r_z;
   logic [1:0]          r_bank;
   logic [NUM_IRQ-1:0]  r_intcon, r_pend, r_irq_prev;
   logic [7:0]          r_ptr [NUM_INDIR];
   logic [DATA_W-1:0]   r_mem [NUM_BANKS][GP_DEPTH];
   logic [DATA_W-1:0]   r_accum, r_accum_bkp, r_rd_raw, r_wr_data;
   logic                r_interrupt, r_byp;
   logic [2:0]          r_irq_vector;
   logic [7:0]          r_rd_addr;
   logic [1:0]          r_rd_bank;

   logic                w_we, w_wr_status, w_take, w_ret, w_byp;
   logic [NUM_INDIR-1:0] w_wr_ptr;
   logic [7:0]          w_ptr_val, w_eff, w_rd_off, w_wr_off;
   logic [1:0]          w_rd_bank;
   logic [BANK_W-1:0]   w_rd_bidx, w_wr_bidx;
   logic                w_rd_gp, w_wr_gp, w_rd_ptr;
   logic [DATA_W-1:0]   w_rd_val;
   logic [NUM_IRQ-1:0]  w_active, w_set, w_w1c, w_ret_clr;
   logic [2:0]          w_lowest;

   function automatic logic [BANK_W-1:0] bank_idx(input logic [1:0] b);
      return (NUM_BANKS == 1) ? '0 : b[BANK_W-1:0];
   endfunction

   assign w_we        = write_en & ~pause;
   assign w_wr_status = w_we && (writeaddr == 8'h01);

   // Pointer forwarding: a same-cycle pointer write is seen by the indirect read.
   always_comb begin
      w_wr_ptr  = '0;
      w_ptr_val = '0;
      for (int i = 0; i < NUM_INDIR; i++) begin
         w_wr_ptr[i] = w_we && (writeaddr == 8'(4 + i));
         if (indir_sel == 2'(i))
            w_ptr_val = w_wr_ptr[i] ? writedata[7:0] : r_ptr[i];
      end
   end

   assign w_eff     = indir_read_en ? (w_ptr_val + readaddr) : readaddr;
   assign w_rd_bank = w_wr_status ? writedata[6:5] : r_bank;
   assign w_rd_bidx = bank_idx(w_rd_bank);
   assign w_wr_bidx = bank_idx(r_bank);
   assign w_rd_off  = w_eff - 8'h10;
   assign w_wr_off  = writeaddr - 8'h10;
   assign w_rd_gp   = (w_eff >= 8'h10) && (32'(w_rd_off) < GP_DEPTH) && (32'(w_rd_bidx) < NUM_BANKS);
   assign w_wr_gp   = (writeaddr >= 8'h10) && (32'(w_wr_off) < GP_DEPTH) && (32'(w_wr_bidx) < NUM_BANKS);
   assign w_rd_ptr  = (w_eff >= 8'h04) && (w_eff < 8'(4 + NUM_INDIR));

   always_comb begin
      w_rd_val = '0;
      if (w_eff == 8'h01) begin
         w_rd_val[7]   = r_gie;
         w_rd_val[6:5] = r_bank;
         w_rd_val[1]   = r_c;
         w_rd_val[0]   = r_z;
      end else if (w_eff == 8'h02) begin
         w_rd_val[NUM_IRQ-1:0] = r_intcon;
      end else if (w_eff == 8'h03) begin
         w_rd_val[NUM_IRQ-1:0] = r_pend;
      end else if (w_rd_gp) begin
         w_rd_val = r_mem[w_rd_bidx][w_rd_off[GP_AW-1:0]];
      end
      for (int i = 0; i < NUM_INDIR; i++)
         if (w_eff == 8'(4 + i)) w_rd_val[7:0] = r_ptr[i];
   end

   // Only locations that store write data verbatim are bypassed.
   assign w_byp = w_we && (w_eff == writeaddr) &&
                  (w_rd_ptr || (w_eff == 8'h02) || (w_rd_gp && w_rd_bidx == w_wr_bidx));

   assign w_active  = r_pend & r_intcon;
   assign w_set     = io_irq & ~r_irq_prev & r_intcon;
   assign w_w1c     = (w_we && writeaddr == 8'h03) ? writedata[NUM_IRQ-1:0] : '0;
   assign w_ret     = retint & ~w_take;
   assign w_ret_clr = w_ret ? (NUM_IRQ'(1) << r_irq_vector) : '0;

   always_comb begin
      w_lowest = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (w_active[i]) w_lowest = 3'(i);
   end

   always_ff @(posedge clk) begin
      if (reset)       r_state <= S_IDLE;
      else if (!pause) r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_take) w_state_nxt = S_SERVICE;
         S_SERVICE: if (retint) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_take = 1'b0;
      if (r_state == S_IDLE) w_take = r_gie & (|w_active);
   end

   always_ff @(posedge clk) begin
      if (!reset && w_we && w_wr_gp)
         r_mem[w_wr_bidx][w_wr_off[GP_AW-1:0]] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gie <= 1'b0; r_c <= 1'b0; r_z <= 1'b0; r_bank <= '0;
         r_intcon <= '0; r_pend <= '0; r_irq_prev <= '0;
         for (int i = 0; i < NUM_INDIR; i++) r_ptr[i] <= '0;
         r_accum <= '0; r_accum_bkp <= '0; r_rd_raw <= '0; r_wr_data <= '0;
         r_interrupt <= 1'b0; r_byp <= 1'b0; r_irq_vector <= '0;
         r_rd_addr <= '0; r_rd_bank <= '0;
      end else if (!pause) begin
         if (w_wr_status) begin
            r_gie  <= writedata[7];
            r_bank <= writedata[6:5];
            r_c    <= writedata[1];
            r_z    <= writedata[0];
         end else begin
            if (z_write) r_z <= zin;
            if (c_write) r_c <= cin;
            if (w_ret)   r_gie <= 1'b1;
         end
         if (w_take) begin
            r_gie        <= 1'b0;
            r_irq_vector <= w_lowest;
         end
         r_interrupt <= w_take;
         if (w_we && writeaddr == 8'h02) r_intcon <= writedata[NUM_IRQ-1:0];
         r_pend     <= (r_pend & ~w_w1c & ~w_ret_clr) | w_set;
         r_irq_prev <= io_irq;
         for (int i = 0; i < NUM_INDIR; i++) begin
            if (w_wr_ptr[i])
               r_ptr[i] <= writedata[7:0];
            else if (indir_read_en && indir_postinc && indir_sel == 2'(i))
               r_ptr[i] <= r_ptr[i] + 8'd1;
         end
         if (accum_write) r_accum <= writedata;
         else if (w_ret)  r_accum <= r_accum_bkp;
         if (save_accum)  r_accum_bkp <= r_accum;
         r_rd_addr <= w_eff;
         r_rd_bank <= w_rd_bank;
         r_rd_raw  <= w_rd_val;
         r_byp     <= w_byp;
         r_wr_data <= writedata;
      end
   end

   assign readdata     = (r_rd_addr[7:3] == 5'b00001) ? io_readdata : (r_byp ? r_wr_data : r_rd_raw);
   assign readaddr_out = r_rd_addr;
   assign cout         = r_c;
   assign io_readaddr  = {r_rd_bank, r_rd_addr[2:0]};
   assign io_writeaddr = {r_bank, writeaddr[2:0]};
   assign io_writedata = writedata;
   assign io_write_en  = w_we && (writeaddr[7:3] == 5'b00001);
   assign interrupt    = r_interrupt;
   assign irq_vector   = r_irq_vector;
   assign accum_out    = r_accum;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Scoreboard bench for banked_mem_ctrl: stimulus queues expected read data and
// interrupt vectors, a monitor pops and compares them as the DUT presents them.
module tb_banked_mem_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, pause, write_en, indir_read_en, indir_postinc;
   logic [7:0] writeaddr, writedata, readaddr, readdata, readaddr_out, accum_out;
   logic [7:0] io_writedata, io_readdata;
   logic [1:0] indir_sel;
   logic       zin, z_write, cin, c_write, cout, interrupt, retint, save_accum, accum_write;
   logic       io_write_en;
   logic [7:0] io_irq;
   logic [4:0] io_readaddr, io_writeaddr;
   logic [2:0] irq_vector;

   banked_mem_ctrl dut (
      .clk(clk), .reset(reset), .pause(pause),
      .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
      .readaddr(readaddr), .indir_sel(indir_sel), .indir_read_en(indir_read_en),
      .indir_postinc(indir_postinc), .readdata(readdata), .readaddr_out(readaddr_out),
      .zin(zin), .z_write(z_write), .cin(cin), .c_write(c_write), .cout(cout),
      .io_irq(io_irq), .io_readaddr(io_readaddr), .io_readdata(io_readdata),
      .io_writeaddr(io_writeaddr), .io_writedata(io_writedata), .io_write_en(io_write_en),
      .interrupt(interrupt), .irq_vector(irq_vector), .retint(retint),
      .save_accum(save_accum), .accum_write(accum_write), .accum_out(accum_out)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] rd_q[$];
   logic [2:0] irq_q[$];
   logic       rd_issue = 1'b0;
   logic       chk_now  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) chk_now <= rd_issue;

   always @(negedge clk) begin
      if (chk_now) begin
         if (rd_q.size() == 0) check("readdata_unexpected", 1, 0);
         else check("readdata", readdata, rd_q.pop_front());
      end
      if (interrupt) begin
         if (irq_q.size() == 0) check("interrupt_unexpected", 1, 0);
         else check("irq_vector", irq_vector, irq_q.pop_front());
      end
   end

   task automatic clear();
      pause = 0; write_en = 0; writeaddr = 0; writedata = 0; readaddr = 0;
      indir_sel = 0; indir_read_en = 0; indir_postinc = 0;
      zin = 0; z_write = 0; cin = 0; c_write = 0; io_irq = 0;
      retint = 0; save_accum = 0; accum_write = 0; rd_issue = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
      clear();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      write_en = 1; writeaddr = a; writedata = d;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      readaddr = a; rd_issue = 1; rd_q.push_back(e);
   endtask

   task automatic ird(input logic [1:0] s, input logic [7:0] off, input logic inc, input logic [7:0] e);
      indir_read_en = 1; indir_sel = s; indir_postinc = inc; rd(off, e);
   endtask

   initial begin
      io_readdata = 8'hC3;
      clear();
      reset = 1;
      repeat (3) step();
      check("rst_readdata", readdata, 8'h00);
      check("rst_accum", accum_out, 8'h00);
      check("rst_cout", cout, 1'b0);
      check("rst_interrupt", interrupt, 1'b0);
      check("rst_irq_vector", irq_vector, 3'd0);
      reset = 0;
      step();

      // Banked GP RAM, bank forwarding on a same-cycle STATUS write
      wr(8'h20, 8'h5A); step();
      wr(8'h01, 8'h40); step();
      wr(8'h20, 8'hA5); step();
      rd(8'h20, 8'hA5); step();
      wr(8'h01, 8'h00); rd(8'h20, 8'h5A); step();
      rd(8'h01, 8'h00); step();

      // Write/read bypass, zero register
      wr(8'h14, 8'h33); rd(8'h14, 8'h33); step();
      rd(8'h14, 8'h33); step();
      wr(8'h00, 8'hFF); step();
      rd(8'h00, 8'h00); step();

      // Indirect pointers, wrap, forwarding, write-over-increment
      wr(8'h04, 8'hFF); step();
      ird(2'd0, 8'h01, 1'b1, 8'h00); step();
      check("readaddr_out_wrap", readaddr_out, 8'h00);
      rd(8'h04, 8'h00); step();
      wr(8'h05, 8'h10); ird(2'd1, 8'h04, 1'b0, 8'h33); step();
      wr(8'h04, 8'h20); ird(2'd0, 8'h00, 1'b1, 8'h5A); step();
      rd(8'h04, 8'h20); step();
      ird(2'd1, 8'h10, 1'b1, 8'h5A); step();
      rd(8'h05, 8'h11); step();

      // I/O window
      wr(8'h0A, 8'h66); rd(8'h09, 8'hC3); #1;
      check("io_write_en", io_write_en, 1'b1);
      check("io_writeaddr", io_writeaddr, 5'b00010);
      check("io_writedata", io_writedata, 8'h66);
      step();
      check("io_readaddr", io_readaddr, 5'b00001);

      // Flags
      wr(8'h01, 8'h02); z_write = 1; zin = 1; step();
      check("cout_set", cout, 1'b1);
      rd(8'h01, 8'h02); step();
      z_write = 1; zin = 1; c_write = 1; cin = 0; step();
      check("cout_clr", cout, 1'b0);
      rd(8'h01, 8'h01); step();

      // Accumulator
      accum_write = 1; writedata = 8'h11; step();
      save_accum = 1; step();
      accum_write = 1; writedata = 8'h22; step();
      check("accum", accum_out, 8'h22);

      // Pause holds everything
      rd(8'h01, 8'h01); step();
      repeat (3) begin
         pause = 1; wr(8'h20, 8'h77); readaddr = 8'h20;
         z_write = 1; zin = 0; c_write = 1; cin = 1; accum_write = 1; save_accum = 1;
         #1;
         check("pause_io_we", io_write_en, 1'b0);
         step();
         check("pause_readdata", readdata, 8'h01);
      end
      check("pause_accum", accum_out, 8'h22);
      check("pause_cout", cout, 1'b0);
      rd(8'h20, 8'h5A); step();
      rd(8'h01, 8'h01); step();

      // Interrupts: edge latch, priority, retint, re-take
      wr(8'h02, 8'h0A); step();
      wr(8'h01, 8'h80); step();
      io_irq = 8'h0E; irq_q.push_back(3'd1); step();
      step(); step();
      rd(8'h01, 8'h00); step();
      rd(8'h03, 8'h0A); step();
      retint = 1; irq_q.push_back(3'd3); step();
      check("retint_accum", accum_out, 8'h11);
      rd(8'h03, 8'h08); step();
      step(); step();
      rd(8'h01, 8'h00); step();
      retint = 1; step();
      rd(8'h03, 8'h00); step();
      rd(8'h01, 8'h80); step();
      repeat (5) step();

      check("rd_queue_drained", rd_q.size(), 0);
      check("irq_queue_drained", irq_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
